spongent_sponge_ctrl: RTL

Sequencing controller for the Spongent sponge construction. Accepts the message as a stream of r-bit blocks and applies padding. It XORs each block into the rate part of the b-bit state and drives an external permutation engine through a start/done handshake. After absorbing, it squeezes N bits of digest and presents them on a valid/ready output. It sits between the message source and the permutation datapath, replacing ad-hoc absorb sequencing.

---
 rtl/spongent_pkg.sv | 23 ++
 rtl/spongent_pad.sv | 35 +++
 rtl/spongent_sponge_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/spongent_pkg.sv
// Shared types and defaults for the Spongent sponge controller.
// Consumers: spongent_pad, spongent_sponge_ctrl.
package spongent_pkg;

    localparam int N_DEF    = 88;
    localparam int CAP_DEF  = 80;
    localparam int RATE_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABSORB,
        S_ABS_PERM,
        S_PAD,
        S_SQZ_OUT,
        S_SQZ_PERM,
        S_DONE
    } spongent_ctrl_state_t;

    function automatic int squeeze_blocks(input int n, input int rate);
        return n / rate;
    endfunction

endpackage

// File: rtl/spongent_pad.sv
// Masks and pads the final message block (10* padding, MSB-first).
// A full-width last block defers its padding to a separate PAD block.
module spongent_pad
    import spongent_pkg::*;
#(
    parameter int RATE = RATE_DEF,
    localparam int LW = $clog2(RATE + 1)
) (
    input  logic [RATE-1:0] msg_data,
    input  logic [LW-1:0]   msg_len,
    input  logic            msg_last,
    output logic [RATE-1:0] block,
    output logic            pad_pending
);

    always_comb begin
        block       = '0;
        pad_pending = 1'b0;
        if (!msg_last) begin
            block = msg_data;
        end else if (int'(msg_len) >= RATE) begin
            block       = msg_data;
            pad_pending = 1'b1;
        end else begin
            // position p counts from the MSB: data, then the 1, then zeros
            for (int i = 0; i < RATE; i++) begin
                if (RATE - 1 - i < int'(msg_len))
                    block[i] = msg_data[i];
                else if (RATE - 1 - i == int'(msg_len))
                    block[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spongent_sponge_ctrl.sv
// Spongent sponge absorb/squeeze sequencer around an external permutation.
// Optional perm_count output enabled by SPONGENT_CTRL_PERM_COUNT_EN.
module spongent_sponge_ctrl
    import spongent_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int CAP  = CAP_DEF,
    parameter int RATE = RATE_DEF,
    localparam int B  = CAP + RATE,
    localparam int LW = $clog2(RATE + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            msg_valid,
    output logic            msg_ready,
    input  logic [RATE-1:0] msg_data,
    input  logic            msg_last,
    input  logic [LW-1:0]   msg_len,
    output logic            perm_start,
    output logic [B-1:0]    perm_din,
    input  logic            perm_done,
    input  logic [B-1:0]    perm_dout,
    output logic [N-1:0]    hash,
    output logic            hash_valid,
    input  logic            hash_ready,
    output logic            busy
`ifdef SPONGENT_CTRL_PERM_COUNT_EN
    ,
    output logic [15:0]     perm_count
`endif
);

    localparam int SQZ = squeeze_blocks(N, RATE);
    localparam int CW  = $clog2(SQZ + 1);

    spongent_ctrl_state_t fsm, fsm_d;
    logic [B-1:0]  st, st_d;
    logic [N-1:0]  hash_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          pad_q, pad_d;
    logic          last_q, last_d;
    logic          start_q, start_d;
    logic [RATE-1:0] blk;
    logic          blk_pad;

    spongent_pad #(.RATE(RATE)) u_pad (
        .msg_data    (msg_data),
        .msg_len     (msg_len),
        .msg_last    (msg_last),
        .block       (blk),
        .pad_pending (blk_pad)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm     <= S_IDLE;
            st      <= '0;
            hash    <= '0;
            cnt     <= '0;
            pad_q   <= 1'b0;
            last_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            fsm     <= fsm_d;
            st      <= st_d;
            hash    <= hash_d;
            cnt     <= cnt_d;
            pad_q   <= pad_d;
            last_q  <= last_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        fsm_d      = fsm;
        st_d       = st;
        hash_d     = hash;
        cnt_d      = cnt;
        pad_d      = pad_q;
        last_d     = last_q;
        start_d    = 1'b0;
        msg_ready  = 1'b0;
        hash_valid = 1'b0;
        busy       = (fsm != S_IDLE);
        unique case (fsm)
            S_IDLE, S_ABSORB: begin
                // held low while reset is asserted
                msg_ready = !rst;
                if (msg_valid && msg_ready) begin
                    st_d[RATE-1:0] = st[RATE-1:0] ^ blk;
                    pad_d   = blk_pad;
                    last_d  = msg_last;
                    start_d = 1'b1;
                    fsm_d   = S_ABS_PERM;
                end
            end
            S_ABS_PERM: begin
                if (perm_done) begin
                    st_d = perm_dout;
                    if (!last_q)
                        fsm_d = S_ABSORB;
                    else if (pad_q)
                        fsm_d = S_PAD;
                    else
                        fsm_d = S_SQZ_OUT;
                end
            end
            S_PAD: begin
                st_d[RATE-1] = ~st[RATE-1];
                pad_d   = 1'b0;
                start_d = 1'b1;
                fsm_d   = S_ABS_PERM;
            end
            S_SQZ_OUT: begin
                hash_d = N'({hash, st[RATE-1:0]});
                cnt_d  = cnt + 1'b1;
                if (cnt_d == CW'(SQZ)) begin
                    fsm_d = S_DONE;
                end else begin
                    start_d = 1'b1;
                    fsm_d   = S_SQZ_PERM;
                end
            end
            S_SQZ_PERM: begin
                if (perm_done) begin
                    st_d  = perm_dout;
                    fsm_d = S_SQZ_OUT;
                end
            end
            S_DONE: begin
                hash_valid = 1'b1;
                if (hash_ready) begin
                    st_d   = '0;
                    cnt_d  = '0;
                    pad_d  = 1'b0;
                    last_d = 1'b0;
                    fsm_d  = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    assign perm_start = start_q;
    assign perm_din   = st;

`ifdef SPONGENT_CTRL_PERM_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perm_count <= '0;
        else if (fsm == S_DONE && hash_ready)
            perm_count <= '0;
        else if (start_q && perm_count != 16'hFFFF)
            perm_count <= perm_count + 16'd1;
    end
`endif

endmodule
